seq_detect_mealy: RTL and testbench

Parametrised Mealy sequence detector for streams of SYM_W-bit symbols. It matches a run-time programmable pattern of up to MAX_LEN symbols, using prefix-fallback so partial matches are never lost, then classifies the next symbol by parity on a 2-bit `done` output. It is the generalised successor of the fixed 000-110-000 detector. It sits between a symbol source and downstream result logic, and keeps a saturating count of completed detections.

---
 rtl/seq_detect_mealy.sv | 195 +++++++++++++++++++
 tb/tb_seq_detect_mealy.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_mealy.sv
// Mealy detector for a programmable SYM_W-bit symbol pattern with prefix fallback.
// A completed match arms the block; the next symbol is classified by its parity on done.
module seq_detect_mealy #(
  parameter int SYM_W   = 3,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = $clog2(MAX_LEN),
  localparam int LEN_W  = $clog2(MAX_LEN) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] sym,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [SYM_W-1:0] cfg_sym,
  input  logic             cfg_len_we,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  output logic [1:0]       done,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int               LEN_RST = (MAX_LEN < 3) ? MAX_LEN : 3;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  typedef enum logic [0:0] {
    ST_HUNT  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t             state_r, state_nxt;
  logic [LEN_W-1:0]   cnt_r, cnt_nxt;
  logic [LEN_W-1:0]   len_r, len_nxt;
  logic [CNT_W-1:0]   match_cnt_r, match_cnt_nxt;
  logic [SYM_W-1:0]   hist_r     [MAX_LEN];
  logic [SYM_W-1:0]   hist_nxt   [MAX_LEN];
  logic [SYM_W-1:0]   hist_shift_s [MAX_LEN];
  logic [SYM_W-1:0]   pat_r      [MAX_LEN];
  logic [SYM_W-1:0]   pat_nxt    [MAX_LEN];
  logic [LEN_W-1:0]   bound_s;
  logic [LEN_W-1:0]   cnt_inc_s;
  logic [LEN_W-1:0]   k_s;
  logic [1:0]         done_s;
  logic               cfg_hit_s;

  // Power-on pattern 000-110-000, truncated or zero-extended to SYM_W.
  function automatic logic [SYM_W-1:0] default_pat(input int slot);
    logic [2:0] v;
    case (slot)
      0:       v = 3'b000;
      1:       v = 3'b110;
      2:       v = 3'b000;
      default: v = 3'b000;
    endcase
    return SYM_W'(v);
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    logic [LEN_W-1:0] r;
    if (l == LEN_W'(0)) begin
      r = LEN_W'(1);
    end else if (l > LEN_MAX) begin
      r = LEN_MAX;
    end else begin
      r = l;
    end
    return r;
  endfunction

  assign cfg_hit_s = cfg_we | cfg_len_we;
  assign cnt_inc_s = cnt_r + LEN_W'(1);

  // History as it would look after accepting the current symbol (index 0 = newest).
  always_comb begin
    hist_shift_s[0] = sym;
    for (int i = 1; i < MAX_LEN; i++) begin
      hist_shift_s[i] = hist_r[i-1];
    end
  end

  // While armed the full pattern is the live match, so fallback may look back len symbols.
  always_comb begin
    if (state_r == ST_ARMED) begin
      bound_s = len_r;
    end else if (cnt_inc_s < len_r) begin
      bound_s = cnt_inc_s;
    end else begin
      bound_s = len_r;
    end
  end

  // Longest pattern prefix (up to bound_s) that ends at the incoming symbol.
  always_comb begin : match_len_p
    logic             ok_v;
    logic [LEN_W-1:0] best_v;
    best_v = LEN_W'(0);
    ok_v   = 1'b0;
    for (int k = 1; k <= MAX_LEN; k++) begin
      ok_v = 1'b1;
      for (int j = 0; j < k; j++) begin
        ok_v = ok_v & (hist_shift_s[k-1-j] == pat_r[j]);
      end
      best_v = (ok_v && (LEN_W'(k) <= bound_s)) ? LEN_W'(k) : best_v;
    end
    k_s = best_v;
  end

  // Next-state and Mealy output; config writes take priority and drop the symbol.
  always_comb begin
    state_nxt     = state_r;
    cnt_nxt       = cnt_r;
    len_nxt       = len_r;
    match_cnt_nxt = match_cnt_r;
    hist_nxt      = hist_r;
    pat_nxt       = pat_r;
    done_s        = 2'b00;
    if (cfg_hit_s) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        pat_nxt[i]  = (cfg_we && (cfg_idx == IDX_W'(i))) ? cfg_sym : pat_r[i];
        hist_nxt[i] = '0;
      end
      len_nxt   = cfg_len_we ? clamp_len(cfg_len) : len_r;
      state_nxt = ST_HUNT;
      cnt_nxt   = LEN_W'(0);
    end else if (sym_valid) begin
      case (state_r)
        ST_HUNT: begin
          hist_nxt = hist_shift_s;
          if (k_s == len_r) begin
            state_nxt = ST_ARMED;
            cnt_nxt   = LEN_W'(0);
          end else begin
            state_nxt = ST_HUNT;
            cnt_nxt   = k_s;
          end
        end
        ST_ARMED: begin
          done_s        = sym[0] ? 2'b10 : 2'b01;
          match_cnt_nxt = (match_cnt_r == {CNT_W{1'b1}}) ? match_cnt_r
                                                         : match_cnt_r + CNT_W'(1);
          if (cfg_overlap) begin
            hist_nxt = hist_shift_s;
            if (k_s == len_r) begin
              state_nxt = ST_ARMED;
              cnt_nxt   = LEN_W'(0);
            end else begin
              state_nxt = ST_HUNT;
              cnt_nxt   = k_s;
            end
          end else begin
            for (int i = 0; i < MAX_LEN; i++) begin
              hist_nxt[i] = '0;
            end
            state_nxt = ST_HUNT;
            cnt_nxt   = LEN_W'(0);
          end
        end
        default: begin
          state_nxt = ST_HUNT;
          cnt_nxt   = LEN_W'(0);
        end
      endcase
    end else begin
      done_s = 2'b00;
    end
  end

  // State registers with asynchronous reset to the power-on configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_HUNT;
      cnt_r       <= LEN_W'(0);
      len_r       <= LEN_W'(LEN_RST);
      match_cnt_r <= CNT_W'(0);
      for (int i = 0; i < MAX_LEN; i++) begin
        hist_r[i] <= '0;
        pat_r[i]  <= default_pat(i);
      end
    end else begin
      state_r     <= state_nxt;
      cnt_r       <= cnt_nxt;
      len_r       <= len_nxt;
      match_cnt_r <= match_cnt_nxt;
      hist_r      <= hist_nxt;
      pat_r       <= pat_nxt;
    end
  end

  assign done      = done_s;
  assign armed     = (state_r == ST_ARMED);
  assign match_cnt = match_cnt_r;

endmodule

// File: tb/tb_seq_detect_mealy.sv
// Bench for seq_detect_mealy: directed scenarios plus random traffic, checked every
// cycle against a suffix-matching model of the accepted symbol stream.
module tb_seq_detect_mealy;

  logic        clk;
  logic        rst_n;
  logic        sym_valid;
  logic [2:0]  sym;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [2:0]  cfg_sym;
  logic        cfg_len_we;
  logic [3:0]  cfg_len;
  logic        cfg_overlap;
  logic [1:0]  done, done_sm;
  logic        armed, armed_sm;
  logic [15:0] match_cnt;
  logic [1:0]  match_cnt_sm;

  int checks = 0;
  int errors = 0;
  logic ov_g = 1'b0;

  // Model: pattern, length, armed flag, accepted stream since last clear, detections.
  logic [2:0] m_pat [8];
  int         m_len;
  logic       m_armed;
  logic [2:0] m_q [$];
  int         m_count;

  seq_detect_mealy dut (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym(sym),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sym(cfg_sym),
    .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .done(done), .armed(armed), .match_cnt(match_cnt)
  );

  seq_detect_mealy #(.CNT_W(2)) dut_sm (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym(sym),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sym(cfg_sym),
    .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .done(done_sm), .armed(armed_sm), .match_cnt(match_cnt_sm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_pat[i] = 3'b000;
    m_pat[1] = 3'b110;
    m_len    = 3;
    m_armed  = 1'b0;
    m_q.delete();
    m_count  = 0;
  endtask

  // Longest suffix of the accepted stream that equals a pattern prefix (capped at len).
  function automatic int longest();
    int n;
    int lim;
    bit ok;
    n   = m_q.size();
    lim = (n < m_len) ? n : m_len;
    for (int k = lim; k >= 1; k--) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) if (m_q[n-k+j] != m_pat[j]) ok = 1'b0;
      if (ok) return k;
    end
    return 0;
  endfunction

  task automatic push_sym(input logic [2:0] s);
    m_q.push_back(s);
    if (m_q.size() > 8) void'(m_q.pop_front());
  endtask

  task automatic model_step();
    if (!rst_n) return;
    if (cfg_we || cfg_len_we) begin
      if (cfg_we) m_pat[cfg_idx] = cfg_sym;
      if (cfg_len_we) m_len = (cfg_len == 4'd0) ? 1 : ((cfg_len > 4'd8) ? 8 : int'(cfg_len));
      m_q.delete();
      m_armed = 1'b0;
    end else if (sym_valid) begin
      if (m_armed) begin
        m_count++;
        if (cfg_overlap) begin
          push_sym(sym);
          m_armed = (longest() == m_len);
        end else begin
          m_q.delete();
          m_armed = 1'b0;
        end
      end else begin
        push_sym(sym);
        m_armed = (longest() == m_len);
      end
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always begin
    logic [1:0] exp_done;
    @(negedge clk);
    #2;
    exp_done = 2'b00;
    if (rst_n && m_armed && sym_valid && !cfg_we && !cfg_len_we)
      exp_done = sym[0] ? 2'b10 : 2'b01;
    chk("done", done, exp_done);
    chk("armed", armed, m_armed);
    chk("match_cnt", match_cnt, (m_count > 65535) ? 65535 : m_count);
    chk("done_sm", done_sm, exp_done);
    chk("armed_sm", armed_sm, m_armed);
    chk("match_cnt_sm", match_cnt_sm, (m_count > 3) ? 3 : m_count);
  end

  task automatic step(input logic v, input logic [2:0] s, input logic we, input logic [2:0] idx,
                      input logic [2:0] cs, input logic lwe, input logic [3:0] l, input int exp_d);
    @(negedge clk);
    sym_valid = v; sym = s; cfg_we = we; cfg_idx = idx; cfg_sym = cs;
    cfg_len_we = lwe; cfg_len = l; cfg_overlap = ov_g;
    #3;
    if (exp_d >= 0) chk("lit_done", done, exp_d);
    @(posedge clk);
    model_step();
  endtask

  task automatic feed(input logic [2:0] s, input int exp_d);
    step(1'b1, s, 1'b0, 3'd0, 3'd0, 1'b0, 4'd0, exp_d);
  endtask

  task automatic idle_inputs();
    sym_valid = 1'b0; sym = 3'd0; cfg_we = 1'b0; cfg_idx = 3'd0; cfg_sym = 3'd0;
    cfg_len_we = 1'b0; cfg_len = 4'd0; cfg_overlap = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_sm [5];
    logic [2:0] p8 [8];
    int r;
    logic [3:0] l;
    exp_sm = '{1, 2, 3, 3, 3};
    p8     = '{3'b111, 3'b110, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    chk("rst_done", done, 2'b00);
    chk("rst_armed", armed, 1'b0);
    chk("rst_match_cnt", match_cnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Default pattern, even classify symbol.
    ov_g = 1'b0;
    feed(3'b000, 0); feed(3'b110, 0); feed(3'b000, 0);
    #1 chk("t1_armed", armed, 1'b1);
    feed(3'b110, 1);
    #1 chk("t1_cnt", match_cnt, 16'd1);

    // Odd classify, then fallback keeps the second 000 as a prefix.
    do_reset();
    feed(3'b000, 0); feed(3'b110, 0); feed(3'b000, 0); feed(3'b001, 2);
    feed(3'b000, 0); feed(3'b000, 0); feed(3'b110, 0); feed(3'b000, 0); feed(3'b010, 1);
    #1 chk("t2_cnt", match_cnt, 16'd2);

    // len=2, pattern 101 101, with and without overlap.
    do_reset();
    ov_g = 1'b1;
    step(1'b0, 3'd0, 1'b1, 3'd0, 3'b101, 1'b0, 4'd0, 0);
    step(1'b0, 3'd0, 1'b1, 3'd1, 3'b101, 1'b1, 4'd2, 0);
    feed(3'b101, 0); feed(3'b101, 0); feed(3'b101, 2); feed(3'b101, 2);
    step(1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1, 4'd2, 0);
    ov_g = 1'b0;
    feed(3'b101, 0); feed(3'b101, 0); feed(3'b101, 2); feed(3'b101, 0);

    // Asynchronous reset while armed and mid-classify.
    do_reset();
    feed(3'b000, 0); feed(3'b110, 0); feed(3'b000, 0); feed(3'b110, 1);
    #1 chk("t4_cnt_pre", match_cnt, 16'd1);
    feed(3'b000, 0); feed(3'b110, 0); feed(3'b000, 0);
    #1 chk("t4_armed_pre", armed, 1'b1);
    @(negedge clk);
    sym_valid = 1'b1; sym = 3'b001;
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t4_done_rst", done, 2'b00);
    chk("t4_armed_rst", armed, 1'b0);
    chk("t4_cnt_rst", match_cnt, 16'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    feed(3'b000, 0); feed(3'b110, 0); feed(3'b000, 0);
    #1 chk("t4_armed_post", armed, 1'b1);

    // Config write mid-match drops the symbol; then length clamping both ways.
    do_reset();
    feed(3'b000, 0); feed(3'b110, 0);
    step(1'b1, 3'b000, 1'b1, 3'd0, 3'b111, 1'b0, 4'd0, 0);
    feed(3'b111, 0); feed(3'b110, 0); feed(3'b000, 0);
    #1 chk("t5_armed", armed, 1'b1);
    step(1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1, 4'd0, 0);
    feed(3'b111, 0);
    #1 chk("t5_len1_armed", armed, 1'b1);
    feed(3'b010, 1);
    step(1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1, 4'd15, 0);
    for (int i = 0; i < 8; i++) feed(p8[i], 0);
    #1 chk("t5_len8_armed", armed, 1'b1);
    feed(3'b011, 2);

    // Saturation of a 2-bit detection counter.
    do_reset();
    step(1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1, 4'd0, 0);
    for (int i = 0; i < 5; i++) begin
      feed(3'b000, 0);
      feed(3'b000, 1);
      #1;
      chk("t6_cnt_sm", match_cnt_sm, exp_sm[i]);
      chk("t6_cnt", match_cnt, i + 1);
    end

    // Random traffic with occasional reprogramming.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r    = $urandom_range(0, 99);
      ov_g = 1'($urandom_range(0, 1));
      l    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 4));
      if (r < 4)
        step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), 1'b1, 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), l, -1);
      else if (r < 6)
        step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), 1'b0, 3'd0, 3'd0, 1'b1, l, -1);
      else
        step(r < 85, 3'($urandom_range(0, 3)), 1'b0, 3'd0, 3'd0, 1'b0, 4'd0, -1);
    end

    @(negedge clk);
    idle_inputs();
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
